sar_conv_ctrl: RTL
==================

Name: sar_conv_ctrl

Overview:
Conversion sequencer for the 6-bit SAR ADC datapath (sample switch, capacitive DAC, comparator).
- On a start request, runs a sample phase, then a MSB-first binary search over WIDTH bit trials with programmable DAC settling time.
- Publishes the held result with a one-cycle end-of-conversion pulse.
- Sits between the tile's user I/O and the analog front end; owns all timing of sample_o and dac_o.

Parameters:
- WIDTH, 6, result/DAC code width (>=1)
- SAMPLE_CYCLES, 2, cycles sample_o is held high per conversion (>=1)
- SETTLE_CYCLES, 1, cycles each trial code is applied before cmp_i is taken (>=1)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- start_i  input  1  conversion request; level-sampled in IDLE
- cmp_i  input  1  comparator output; 1 = Vin >= DAC voltage
- sample_o  output  1  sample switch enable
- dac_o  output  WIDTH  DAC trial code
- result_o  output  WIDTH  last completed conversion, held
- eoc_o  output  1  end-of-conversion pulse, one cycle
- busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; sample_o=0, dac_o=0, result_o=0, eoc_o=0, busy_o=0; internal code/timer/bit index cleared.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- States: IDLE, SAMPLE, TRIAL, DONE.
- IDLE:
  - If start_i=1 at a clock edge -> SAMPLE; code cleared; bit index = WIDTH-1.
  - Otherwise stays in IDLE.
- SAMPLE:
  - sample_o=1, dac_o=0, held for exactly SAMPLE_CYCLES cycles, then -> TRIAL.
- TRIAL (per bit i, WIDTH-1 down to 0):
  - dac_o = code | (1<<i) for SETTLE_CYCLES cycles.
  - At the edge ending the last settle cycle, cmp_i is sampled. If cmp_i=1, bit i is kept in code; if 0, it is cleared.
  - If i=0 -> DONE; otherwise i decrements and the next trial starts.
- DONE:
  - result_o loaded with the final code at the edge entering DONE.
  - eoc_o=1 for this single cycle; dac_o=0.
  - -> IDLE next cycle.
- Latency: eoc_o is high SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES cycles after the edge that accepted start_i. Defaults: 8 cycles.
- start_i outside IDLE is ignored; there is no queuing.
- start_i held high gives back-to-back conversions with a period of 2 + SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES (defaults: 10).
- result_o changes only on DONE entry or reset.
- Reset asserted mid-conversion: immediate return to IDLE; result_o=0; no eoc_o is produced.
- WIDTH=1: a single trial at dac_o=1.
- Timer is a down-counter sized ceil(log2(max(SAMPLE_CYCLES, SETTLE_CYCLES)))+1; no wrap-around is reachable.

Optional Feature:
- SAR_CONT_EN defined:
  - Adds input cont_i (1 bit).
  - In DONE, if cont_i=1 the next state is SAMPLE instead of IDLE. This gives free-running conversion with period 1 + SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES (defaults: 9).
  - busy_o stays high across conversions; eoc_o still pulses once per conversion.
- SAR_CONT_EN undefined:
  - No cont_i port; DONE always goes to IDLE.

Decomposition:
- Package sar_ctrl_pkg:
  - state encoding constants (IDLE=2'd0, SAMPLE=2'd1, TRIAL=2'd2, DONE=2'd3)
  - default WIDTH/SAMPLE_CYCLES/SETTLE_CYCLES constants
- One sub-module, sar_phase_timer:
  - loadable down-counter with a terminal-count flag.
  - Shared by the SAMPLE and TRIAL phases.
- The FSM, code register and bit index stay in sar_conv_ctrl.

Test Plan:
- Defaults; behavioural comparator cmp_i = (37 >= dac_o); pulse start_i -> sample_o high 2 cycles; dac_o sequence 32,48,40,36,38,37; result_o=37 (100101); eoc_o high exactly 8 cycles after accept, one cycle wide.
- Vin=0 and Vin=63 -> dac_o 32,16,8,4,2,1 / 32,48,56,60,62,63; result_o=0 / 63; no overflow.
- start_i pulsed again during TRIAL -> ignored; exactly one eoc_o; result_o unchanged until DONE.
- start_i held high, Vin stepping 10 -> 20 -> eoc_o every 10 cycles; result_o 10 then 20; busy_o low for one cycle (IDLE) between conversions.
- rst_n low during third trial -> all outputs 0 asynchronously; no eoc_o; a subsequent start gives a correct conversion.
- SAR_CONT_EN, cont_i=1, SETTLE_CYCLES=2 -> eoc_o every 15 cycles; busy_o continuously high; each dac_o code held 2 cycles.

Source files
------------

// File: rtl/sar_ctrl_pkg.sv
// Shared definitions for the SAR conversion sequencer: state encoding,
// default geometry and the phase-timer width helper.
package sar_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      TRIAL  = 2'd2,
      DONE   = 2'd3
   } sar_state_e;

   localparam int DEF_WIDTH         = 6;
   localparam int DEF_SAMPLE_CYCLES = 2;
   localparam int DEF_SETTLE_CYCLES = 1;

   // Down-counter only ever holds (phase length - 1), so this width never wraps.
   function automatic int timer_width(input int sample_cycles, input int settle_cycles);
      int longest;
      longest = (sample_cycles > settle_cycles) ? sample_cycles : settle_cycles;
      return $clog2(longest) + 1;
   endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// Loadable down-counter with a terminal-count flag; times both the sample
// window and each DAC settle window of the SAR sequencer.
module sar_phase_timer #(
   parameter int TW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic [TW-1:0] load_val_i,
   input  logic          dec_i,
   output logic          tc_o
);

   logic [TW-1:0] count_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - TW'(1);
      end
   end

   assign tc_o = (count_q == '0);

endmodule

// File: rtl/sar_conv_ctrl.sv
// SAR ADC conversion sequencer: sample phase, MSB-first binary search, held
// result with a one-cycle eoc pulse. Define SAR_CONT_EN for free-running mode.
module sar_conv_ctrl
   import sar_ctrl_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
`ifdef SAR_CONT_EN
   input  logic             cont_i,
`endif
   input  logic             cmp_i,
   output logic             sample_o,
   output logic [WIDTH-1:0] dac_o,
   output logic [WIDTH-1:0] result_o,
   output logic             eoc_o,
   output logic             busy_o
);

   localparam int TW = timer_width(SAMPLE_CYCLES, SETTLE_CYCLES);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [TW-1:0] SAMPLE_LOAD = TW'(SAMPLE_CYCLES - 1);
   localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
   localparam logic [IW-1:0] TOP_BIT     = IW'(WIDTH - 1);

   sar_state_e       state_q;
   logic [WIDTH-1:0] code_q;
   logic [IW-1:0]    bit_q;
   logic [WIDTH-1:0] dac_q;
   logic [WIDTH-1:0] result_q;
   logic             sample_q;
   logic             eoc_q;
   logic             busy_q;

   logic [WIDTH-1:0] trial_bit;
   logic [WIDTH-1:0] next_bit;
   logic [WIDTH-1:0] code_d;
   logic             restart;

   logic             timer_load;
   logic             timer_dec;
   logic [TW-1:0]    timer_val;
   logic             timer_tc;

`ifdef SAR_CONT_EN
   assign restart = cont_i;
`else
   assign restart = 1'b0;
`endif

   // code_q never holds the bit under trial, so OR-ing keeps or drops it.
   always_comb begin
      trial_bit = WIDTH'(1) << bit_q;
      next_bit  = WIDTH'(1) << (bit_q - IW'(1));
      code_d    = cmp_i ? (code_q | trial_bit) : code_q;
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      timer_val  = SAMPLE_LOAD;
      unique case (state_q)
         IDLE:   timer_load = start_i;
         SAMPLE, TRIAL: begin
            if (timer_tc) begin
               timer_load = 1'b1;
               timer_val  = SETTLE_LOAD;
            end else begin
               timer_dec  = 1'b1;
            end
         end
         DONE:   timer_load = restart;
         default: ;
      endcase
   end

   sar_phase_timer #(
      .TW (TW)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .dec_i      (timer_dec),
      .tc_o       (timer_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         code_q   <= '0;
         bit_q    <= '0;
         dac_q    <= '0;
         result_q <= '0;
         sample_q <= 1'b0;
         eoc_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q  <= SAMPLE;
                  code_q   <= '0;
                  bit_q    <= TOP_BIT;
                  dac_q    <= '0;
                  sample_q <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            SAMPLE: begin
               if (timer_tc) begin
                  state_q  <= TRIAL;
                  sample_q <= 1'b0;
                  dac_q    <= code_q | trial_bit;
               end
            end
            TRIAL: begin
               if (timer_tc) begin
                  code_q <= code_d;
                  if (bit_q == '0) begin
                     state_q  <= DONE;
                     result_q <= code_d;
                     dac_q    <= '0;
                     eoc_q    <= 1'b1;
                  end else begin
                     bit_q <= bit_q - IW'(1);
                     dac_q <= code_d | next_bit;
                  end
               end
            end
            DONE: begin
               eoc_q <= 1'b0;
               if (restart) begin
                  state_q  <= SAMPLE;
                  code_q   <= '0;
                  bit_q    <= TOP_BIT;
                  sample_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sample_o = sample_q;
   assign dac_o    = dac_q;
   assign result_o = result_q;
   assign eoc_o    = eoc_q;
   assign busy_o   = busy_q;

endmodule
